// File: rtl/ic74hc153_mux.sv
// 4-to-1 multiplexer modelled on the 74HC153: a combinational output, a strobed
// registered copy, and a saturating count of select-line changes.
module ic74hc153_mux #(
   parameter int CNT_W = 8
) (
   input  logic [3:0]       data,
   input  logic [1:0]       sel,
   output logic             out,
   input  logic             clk,
   input  logic             n_reset,
   input  logic             strobe_n,
   output logic             out_q,
   output logic [CNT_W-1:0] sel_changes
);

   logic             cap_d, cap_q;
   logic [1:0]       sel_prev_d, sel_prev_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_comb begin
      out        = data[sel];
      cap_d      = strobe_n ? 1'b0 : data[sel];
      sel_prev_d = sel;
      cnt_d      = cnt_q;
      if (sel != sel_prev_q) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cap_q      <= 1'b0;
         sel_prev_q <= 2'b00;
         cnt_q      <= '0;
      end else begin
         cap_q      <= cap_d;
         sel_prev_q <= sel_prev_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_q       = cap_q;
   assign sel_changes = cnt_q;

endmodule

// File: tb/tb_ic74hc153_mux.sv
// Directed bench for ic74hc153_mux: combinational sweeps, strobed capture,
// select-change counting with saturation, and asynchronous reset behaviour.
module tb_ic74hc153_mux;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [3:0] data;
   logic [1:0] sel;
   logic       strobe_n;
   logic       out;
   logic       out_q;
   logic [7:0] sel_changes;

   int tests = 0;
   int fails = 0;

   ic74hc153_mux #(.CNT_W(8)) dut (
      .data        (data),
      .sel         (sel),
      .out         (out),
      .clk         (clk),
      .n_reset     (n_reset),
      .strobe_n    (strobe_n),
      .out_q       (out_q),
      .sel_changes (sel_changes)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       probe;
      logic [7:0] exp_cnt;

      n_reset  = 1'b0;
      data     = 4'b0000;
      sel      = 2'b00;
      strobe_n = 1'b0;
      #1;
      check("rst_out_q", out_q, 1'b0);
      check("rst_cnt", sel_changes, 8'd0);

      // Combinational sweeps, registers held in reset
      data = 4'b1010;
      sel = 2'b00; #1; check("sw1_s0", out, 1'b0); #9;
      sel = 2'b01; #1; check("sw1_s1", out, 1'b1); #9;
      sel = 2'b10; #1; check("sw1_s2", out, 1'b0); #9;
      sel = 2'b11; #1; check("sw1_s3", out, 1'b1); #9;
      data = 4'b0101;
      sel = 2'b00; #1; check("sw2_s0", out, 1'b1); #9;
      sel = 2'b01; #1; check("sw2_s1", out, 1'b0); #9;
      sel = 2'b10; #1; check("sw2_s2", out, 1'b1); #9;
      sel = 2'b11; #1; check("sw2_s3", out, 1'b0); #9;
      check("rst_hold_out_q", out_q, 1'b0);
      check("rst_hold_cnt", sel_changes, 8'd0);

      // Release reset; first edge compares sel=01 against sel_prev=00
      @(negedge clk);
      data = 4'b1010; sel = 2'b01; strobe_n = 1'b0; n_reset = 1'b1;
      tick();
      check("first_out_q", out_q, 1'b1);
      check("first_cnt", sel_changes, 8'd1);

      @(negedge clk); strobe_n = 1'b1;
      tick();
      check("strobe_off_out_q", out_q, 1'b0);
      check("strobe_off_out", out, 1'b1);
      check("hold_cnt", sel_changes, 8'd1);

      // One-cycle lag of out_q behind out
      @(negedge clk); strobe_n = 1'b0; sel = 2'b11;
      #1;
      check("lag_out", out, 1'b1);
      check("lag_out_q_before", out_q, 1'b0);
      tick();
      check("lag_out_q_after", out_q, 1'b1);
      check("lag_cnt", sel_changes, 8'd2);
      @(negedge clk); sel = 2'b00;
      #1;
      check("lag2_out", out, 1'b0);
      check("lag2_out_q_before", out_q, 1'b1);
      tick();
      check("lag2_out_q_after", out_q, 1'b0);
      check("lag2_cnt", sel_changes, 8'd3);

      // Strobe and sel change on the same edge
      @(negedge clk); strobe_n = 1'b1; sel = 2'b01;
      tick();
      check("simul1_out_q", out_q, 1'b0);
      check("simul1_cnt", sel_changes, 8'd4);
      @(negedge clk); strobe_n = 1'b0; sel = 2'b11;
      tick();
      check("simul2_out_q", out_q, 1'b1);
      check("simul2_cnt", sel_changes, 8'd5);

      // Unselected data bits must not disturb out
      @(negedge clk); data = 4'b1000;
      #1;
      check("unsel_out", out, 1'b1);

      // Asynchronous reset between edges
      #2; n_reset = 1'b0;
      #1;
      check("async_out_q", out_q, 1'b0);
      check("async_cnt", sel_changes, 8'd0);
      check("async_out_follows", out, 1'b1);
      tick();
      check("rst_clk_out_q", out_q, 1'b0);
      check("rst_clk_cnt", sel_changes, 8'd0);
      @(negedge clk); n_reset = 1'b1;
      tick();
      check("resume_out_q", out_q, 1'b1);
      check("resume_cnt", sel_changes, 8'd1);

      // Saturation: toggle sel every cycle for 300 cycles
      @(negedge clk); n_reset = 1'b0; sel = 2'b00;
      #1; n_reset = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         sel = (i % 2 == 0) ? 2'b01 : 2'b00;
         tick();
         exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         check($sformatf("sat_cnt_%0d", i), sel_changes, exp_cnt);
      end

      // Unknown select propagates to out (only observable on a 4-state simulator)
      @(negedge clk);
      sel = 2'b1x;
      #1;
      probe = 1'bx;
      if (probe === 1'bx) begin
         check("x_sel_out", out, 1'bx);
      end
      data = 4'b1010; sel = 2'b10;
      #1;
      check("x_recover_out", out, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ic74hc153_mux.md
IC74HC153_MUX -- requirements
Module: IC74HC153

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the select-change counter (legal range 2..16).

Ports (listed clock and reset first):
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data, input, 4 bits: mux data inputs C0..C3 (data[0]=C0).
REQ-005 The block SHALL have port sel, input, 2 bits: select {B,A}; sel[1]=B is the MSB.
REQ-006 The block SHALL have port out, output, 1 bit: combinational mux output.
REQ-007 The block SHALL have port strobe_n, input, 1 bit: active-low strobe (1G) that gates only the registered path.
REQ-008 The block SHALL have port out_q, output, 1 bit: registered, strobed mux output.
REQ-009 The block SHALL have port sel_changes, output, CNT_W bits: saturating count of select changes.
REQ-010 Port declaration order SHALL be data, sel, out, clk, n_reset, strobe_n, out_q, sel_changes, so that three-port positional instances (data, sel, out) bind correctly.

Function
REQ-011 out SHALL equal data[sel] combinationally, with zero clock latency and independent of clk, n_reset and strobe_n.
REQ-012 out SHALL be X whenever any bit of sel is X or Z; data bits not currently selected SHALL NOT affect out.
REQ-013 With n_reset high, on each rising clk out_q SHALL load data[sel] when strobe_n=0 and SHALL load 0 when strobe_n=1, matching 74HC153 strobe semantics.
REQ-014 out_q SHALL lag out by exactly one clock cycle when strobe_n is held at 0.
REQ-015 The block SHALL keep an internal register sel_prev, loaded with sel on every rising clk.
REQ-016 sel_changes SHALL increment by 1 on a rising clk when sel differs from sel_prev, and SHALL hold otherwise.
REQ-017 sel_changes SHALL saturate at all-ones (255 for CNT_W=8) and SHALL NOT wrap.
REQ-018 A simultaneous strobe change and sel change in the same cycle SHALL both take effect on that edge.
REQ-019 The first rising clk after reset release SHALL compare sel against the reset value of sel_prev (00).

Reset
REQ-020 When n_reset=0, out_q, sel_prev and sel_changes SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-021 While n_reset=0, the registers SHALL hold 0 regardless of clk, and out SHALL continue to follow data[sel].
REQ-022 Assertion of n_reset mid-operation SHALL discard any pending count or captured data.
REQ-023 Normal updates SHALL resume on the first rising clk after n_reset returns high.

Verification
REQ-024 data=1010, sel stepped 00,01,10,11 at 10-unit intervals -> out = 0,1,0,1.
REQ-025 data=0101, sel stepped 00,01,10,11 -> out = 1,0,1,0; no clock is required for either sweep.
REQ-026 strobe_n=0, data=1010, sel=01, one rising clk -> out_q=1; then strobe_n=1, one rising clk -> out_q=0 while out stays 1.
REQ-027 After reset, sel toggled 00/01 on every cycle for 300 cycles -> sel_changes climbs by 1 per cycle and holds at 255.
REQ-028 With sel_changes=5 and out_q=1, pulse n_reset low between clock edges -> both outputs read 0 before the next edge.
REQ-029 sel driven to 1x -> out = X; after sel returns to 10 with data=1010 -> out = 0.
